// File: rtl/ycr1_arb_mux.sv
// ycr1_arb_mux: command/response sequencer behind a 2-requester round-robin
// arbiter. The block takes the arbiter's registered grant and steers that
// channel's command onto the shared memory port. It routes the memory response
// back to the same channel. It pulses arb_ack when the transaction ends, so only
// one transaction is ever in flight.
// Optional build macro: YCR1_ARB_MUX_TIMEOUT_EN adds a response timeout of
// TMO_CYCLES cycles. When the timeout fires, the channel gets an error response
// with zero data.
module ycr1_arb_mux #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rstn,
  // channel 0
  input  logic          core0_req,
  input  logic          core0_cmd,
  input  logic [AW-1:0] core0_addr,
  input  logic [DW-1:0] core0_wdata,
  input  logic [1:0]    core0_width,
  output logic          core0_req_ack,
  output logic [DW-1:0] core0_rdata,
  output logic [1:0]    core0_resp,
  // channel 1
  input  logic          core1_req,
  input  logic          core1_cmd,
  input  logic [AW-1:0] core1_addr,
  input  logic [DW-1:0] core1_wdata,
  input  logic [1:0]    core1_width,
  output logic          core1_req_ack,
  output logic [DW-1:0] core1_rdata,
  output logic [1:0]    core1_resp,
  // arbiter handshake
  output logic [1:0]    arb_req,
  input  logic [1:0]    arb_gnt,
  output logic          arb_ack,
  // shared memory port
  output logic          mem_req,
  input  logic          mem_req_ack,
  output logic          mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_width,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OK  = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b10;

  state_t state_q, state_d;
  logic   sel_q, sel_d;

  // Response-phase completion: a real memory response, or the timeout.
  logic          rsp_fire;
  logic [1:0]    rsp_code;
  logic [DW-1:0] rsp_data;
  logic          tmo_hit;

  assign arb_req = {core1_req, core0_req};

`ifdef YCR1_ARB_MUX_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TMO_CYCLES);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == RESP) && (tmo_cnt_q == TMO_LIMIT);

  // Timeout counter: cleared on the way into RESP, counts idle RESP cycles.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == CMD && mem_req_ack) begin
      tmo_cnt_d = 8'd0;
    end else if (state_q == RESP && !mem_resp_valid && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int tmo_cycles_unused = TMO_CYCLES;

  assign tmo_hit = 1'b0;
`endif

  // State and channel-select registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Next state: the grant is sampled only in IDLE. Grant 10 counts as no grant.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt == 2'b00) begin
          sel_d   = 1'b0;
          state_d = CMD;
        end else if (arb_gnt == 2'b01) begin
          sel_d   = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem_req_ack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The memory response wins over a timeout in the same cycle.
  // A timeout returns an error with zero data.
  always_comb begin
    rsp_fire = (state_q == RESP) && (mem_resp_valid || tmo_hit);
    rsp_code = RESP_ERR;
    rsp_data = '0;
    if (mem_resp_valid) begin
      rsp_code = mem_resp_err ? RESP_ERR : RESP_OK;
      rsp_data = mem_rdata;
    end
  end

  // Outputs: steer the command in CMD and the response in RESP; zero otherwise.
  always_comb begin
    mem_req       = 1'b0;
    mem_cmd       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_width     = 2'b00;
    core0_req_ack = 1'b0;
    core1_req_ack = 1'b0;
    core0_resp    = 2'b00;
    core1_resp    = 2'b00;
    core0_rdata   = '0;
    core1_rdata   = '0;
    arb_ack       = 1'b0;
    if (state_q == CMD) begin
      mem_req       = 1'b1;
      mem_cmd       = sel_q ? core1_cmd   : core0_cmd;
      mem_addr      = sel_q ? core1_addr  : core0_addr;
      mem_wdata     = sel_q ? core1_wdata : core0_wdata;
      mem_width     = sel_q ? core1_width : core0_width;
      core0_req_ack = mem_req_ack && !sel_q;
      core1_req_ack = mem_req_ack &&  sel_q;
    end
    if (rsp_fire) begin
      arb_ack = 1'b1;
      if (sel_q) begin
        core1_resp  = rsp_code;
        core1_rdata = rsp_data;
      end else begin
        core0_resp  = rsp_code;
        core0_rdata = rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_ycr1_arb_mux.sv
// Directed bench for ycr1_arb_mux: table of single transactions plus reset,
// no-grant and (with YCR1_ARB_MUX_TIMEOUT_EN) timeout sequences.
module tb_ycr1_arb_mux;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core0_req, core0_cmd, core0_req_ack;
  logic [31:0] core0_addr, core0_wdata, core0_rdata;
  logic [1:0]  core0_width, core0_resp;
  logic        core1_req, core1_cmd, core1_req_ack;
  logic [31:0] core1_addr, core1_wdata, core1_rdata;
  logic [1:0]  core1_width, core1_resp;
  logic [1:0]  arb_req, arb_gnt;
  logic        arb_ack;
  logic        mem_req, mem_req_ack, mem_cmd, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ycr1_arb_mux #(.AW(32), .DW(32), .TMO_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .core0_req(core0_req), .core0_cmd(core0_cmd), .core0_addr(core0_addr),
    .core0_wdata(core0_wdata), .core0_width(core0_width),
    .core0_req_ack(core0_req_ack), .core0_rdata(core0_rdata), .core0_resp(core0_resp),
    .core1_req(core1_req), .core1_cmd(core1_cmd), .core1_addr(core1_addr),
    .core1_wdata(core1_wdata), .core1_width(core1_width),
    .core1_req_ack(core1_req_ack), .core1_rdata(core1_rdata), .core1_resp(core1_resp),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_ack(arb_ack),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  typedef struct {
    logic        ch;
    logic [1:0]  reqs;
    logic        cmd;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata;
    logic [1:0]  width;
    int          ack_wait;
    int          resp_wait;
    logic [31:0] mrdata;
    logic        merr;
    logic [31:0] exp_addr;
    logic        exp_cmd;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_width;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    tick();
    if (v.ch == 1'b0) begin
      core0_cmd = v.cmd;  core0_wdata = v.wdata;  core0_width = v.width;
      core1_cmd = ~v.cmd; core1_wdata = ~v.wdata; core1_width = ~v.width;
    end else begin
      core1_cmd = v.cmd;  core1_wdata = v.wdata;  core1_width = v.width;
      core0_cmd = ~v.cmd; core0_wdata = ~v.wdata; core0_width = ~v.width;
    end
    core0_addr = v.addr0;
    core1_addr = v.addr1;
    core0_req  = v.reqs[0];
    core1_req  = v.reqs[1];
    arb_gnt    = v.ch ? 2'b01 : 2'b00;
    @(negedge clk);
    chk("arb_req", 64'(arb_req), 64'(v.reqs));
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    tick();
    // now in CMD
    for (int i = 0; i < v.ack_wait; i++) begin
      @(negedge clk);
      chk("cmd_wait", 64'({mem_req, core0_req_ack, core1_req_ack}), 64'b100);
      tick();
    end
    mem_req_ack = 1'b1;
    @(negedge clk);
    chk("mem_req", 64'(mem_req), 64'd1);
    chk("mem_addr", 64'(mem_addr), 64'(v.exp_addr));
    chk("mem_cmd", 64'(mem_cmd), 64'(v.exp_cmd));
    chk("mem_wdata", 64'(mem_wdata), 64'(v.exp_wdata));
    chk("mem_width", 64'(mem_width), 64'(v.exp_width));
    chk("req_ack", 64'({core1_req_ack, core0_req_ack}), v.ch ? 64'b10 : 64'b01);
    tick();
    // now in RESP
    mem_req_ack = 1'b0;
    if (v.ch) core1_req = 1'b0; else core0_req = 1'b0;
    for (int i = 0; i < v.resp_wait; i++) begin
      @(negedge clk);
      chk("resp_wait", 64'({mem_req, arb_ack, core0_resp, core1_resp}), 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = v.mrdata;
    mem_resp_err   = v.merr;
    @(negedge clk);
    chk("resp", 64'(v.ch ? core1_resp : core0_resp), 64'(v.exp_resp));
    chk("rdata", 64'(v.ch ? core1_rdata : core0_rdata), 64'(v.exp_rdata));
    chk("other_resp", 64'(v.ch ? core0_resp : core1_resp), 64'd0);
    chk("arb_ack", 64'(arb_ack), 64'd1);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    arb_gnt        = 2'b11;
    @(negedge clk);
    chk("post_ack", 64'({mem_req, arb_ack, core0_resp, core1_resp}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 2'b01, 1'b0, 32'h1000, 32'h2000, 32'h0, 2'b10, 2, 3, 32'hDEADBEEF, 1'b0,
                32'h1000, 1'b0, 32'h0, 2'b10, 2'b01, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'b10, 1'b1, 32'h1000, 32'h2004, 32'h55AA, 2'b01, 0, 1, 32'h12345678, 1'b1,
                32'h2004, 1'b1, 32'h55AA, 2'b01, 2'b10, 32'h12345678};
    vecs[2] = '{1'b0, 2'b11, 1'b1, 32'h100, 32'h200, 32'hA5A5A5A5, 2'b00, 1, 0, 32'h0, 1'b0,
                32'h100, 1'b1, 32'hA5A5A5A5, 2'b00, 2'b01, 32'h0};
    vecs[3] = '{1'b1, 2'b11, 1'b0, 32'h104, 32'h204, 32'h0, 2'b10, 0, 2, 32'hCAFEF00D, 1'b0,
                32'h204, 1'b0, 32'h0, 2'b10, 2'b01, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 2'b11, 1'b0, 32'h108, 32'h208, 32'h0, 2'b01, 3, 0, 32'hFFFFFFFF, 1'b1,
                32'h108, 1'b0, 32'h0, 2'b01, 2'b10, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 2'b11, 1'b1, 32'h10C, 32'h20C, 32'h0F0F0F0F, 2'b10, 0, 0, 32'h0, 1'b0,
                32'h20C, 1'b1, 32'h0F0F0F0F, 2'b10, 2'b01, 32'h0};

    rstn = 1'b0;
    core0_req = 0; core0_cmd = 0; core0_addr = 0; core0_wdata = 0; core0_width = 0;
    core1_req = 0; core1_cmd = 0; core1_addr = 0; core1_wdata = 0; core1_width = 0;
    arb_gnt = 2'b11; mem_req_ack = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
    #12;
    chk("rst_ctrl", 64'({mem_req, arb_ack, core0_req_ack, core1_req_ack, core0_resp, core1_resp}), 64'd0);
    chk("rst_data", 64'({core0_rdata, core1_rdata}), 64'd0);
    chk("rst_mem", 64'({mem_cmd, mem_width, mem_addr}), 64'd0);
    tick();
    rstn = 1'b1;

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
    end

    // No valid grant (10 / 11) for 20 cycles while both channels request.
    core0_req = 1'b1;
    core1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      arb_gnt = i[0] ? 2'b10 : 2'b11;
      @(negedge clk);
      chk("nogrant", 64'({mem_req, arb_ack}), 64'd0);
    end
    tick();
    arb_gnt = 2'b11;
    core0_req = 1'b0;
    core1_req = 1'b0;

    // Reset asserted during RESP, together with the memory response.
    tick();
    core0_req = 1'b1; core0_addr = 32'h3000; core0_cmd = 1'b0; arb_gnt = 2'b00;
    tick();
    mem_req_ack = 1'b1;
    @(negedge clk);
    chk("rst_seq_req_ack", 64'(core0_req_ack), 64'd1);
    tick();
    mem_req_ack = 1'b0; core0_req = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'hAAAA5555; arb_gnt = 2'b11;
    rstn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({mem_req, arb_ack, core0_resp, core1_resp}), 64'd0);
    chk("midrst_rdata", 64'(core0_rdata), 64'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_ignore", 64'({mem_req, arb_ack, core0_resp, core1_resp}), 64'd0);
    tick();
    mem_resp_valid = 1'b0;

`ifdef YCR1_ARB_MUX_TIMEOUT_EN
    // No memory response: timeout after 8 RESP cycles.
    tick();
    core0_req = 1'b1; core0_addr = 32'h4000; arb_gnt = 2'b00;
    tick();
    mem_req_ack = 1'b1;
    tick();
    mem_req_ack = 1'b0; core0_req = 1'b0; mem_rdata = 32'h9999;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_wait", 64'({arb_ack, core0_resp}), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("tmo_resp", 64'(core0_resp), 64'b10);
    chk("tmo_rdata", 64'(core0_rdata), 64'd0);
    chk("tmo_ack", 64'(arb_ack), 64'd1);
    tick();
    arb_gnt = 2'b11; mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("tmo_late", 64'({arb_ack, core0_resp, mem_req}), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ycr1_arb_mux.md
Name: ycr1_arb_mux

Overview:
- Datapath and transaction sequencer directly downstream of the 2-requester round-robin arbiter.
- Forwards each requester's req to the arbiter and consumes the registered grant (00 = ch0, 01 = ch1, 11 = none).
- Steers the granted channel's command onto one shared memory port and routes the response back to that channel.
- Pulses the arbiter ack when the transaction completes, so only one transaction is outstanding at a time.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TMO_CYCLES, 255, response timeout in cycles (used only with the optional feature; 1..255)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- core0_req  in  1  ch0 request; held until core0_req_ack
- core0_cmd  in  1  ch0 command: 0 = read, 1 = write
- core0_addr  in  AW  ch0 address
- core0_wdata  in  DW  ch0 write data
- core0_width  in  2  ch0 size: 00 byte, 01 half, 10 word
- core0_req_ack  out  1  ch0 command accepted (1-cycle pulse)
- core0_rdata  out  DW  ch0 read data
- core0_resp  out  2  ch0 response: 00 idle, 01 ok, 10 error
- core1_*  same set as core0_*, for ch1
- arb_req  out  2  {core1_req, core0_req} to arbiter
- arb_gnt  in  2  arbiter registered grant
- arb_ack  out  1  transaction done, to arbiter
- mem_req  out  1  memory request
- mem_req_ack  in  1  memory accepted command
- mem_cmd  out  1  forwarded command
- mem_addr  out  AW  forwarded address
- mem_wdata  out  DW  forwarded write data
- mem_width  out  2  forwarded size
- mem_resp_valid  in  1  memory response valid
- mem_rdata  in  DW  memory read data
- mem_resp_err  in  1  memory error flag, qualified by mem_resp_valid

Behaviour:
- arb_req is purely combinational: {core1_req, core0_req}.
- Reset values: state = IDLE, sel = 0, mem_req = 0, arb_ack = 0, both req_ack = 0, both resp = 00, both rdata = 0. The mem_* command fields are don't-care while mem_req = 0 but drive 0 in reset.
- Three-state FSM: IDLE, CMD, RESP. A 1-bit register sel holds the granted channel.
- IDLE:
  - arb_gnt = 00 → sel = 0, go to CMD.
  - arb_gnt = 01 → sel = 1, go to CMD.
  - arb_gnt = 11 or 10 → stay in IDLE; 10 is treated as no grant.
- CMD:
  - mem_req = 1; mem_cmd, mem_addr, mem_wdata and mem_width are combinationally muxed from channel sel.
  - On mem_req_ack: coreN_req_ack = 1 for channel sel, same cycle (combinational), then go to RESP.
  - If the selected coreN_req has dropped, the request is still issued (protocol violation, not filtered).
- RESP:
  - mem_req = 0.
  - On mem_resp_valid: coreN_resp = 01 (mem_resp_err = 0) or 10 (mem_resp_err = 1), and coreN_rdata = mem_rdata for channel sel, both combinational in the same cycle. arb_ack = 1 for exactly this cycle, then go to IDLE.
  - The non-selected channel's resp stays 00.
- Grant release: the arbiter drops arb_gnt to 11 in the cycle after arb_ack, so IDLE never sees a stale grant. Minimum back-to-back spacing is ack → IDLE(gnt = 11) → re-grant seen → CMD.
- Latency, grant to command: arb_gnt valid in cycle t, mem_req = 1 in cycle t+1.
- A response arriving in the same cycle as mem_req_ack is not supported; memory must respond at least 1 cycle after accept. A mem_resp_valid outside RESP is ignored.
- Reset mid-transaction: all state returns to reset values immediately and asynchronously. The in-flight response is dropped and no ack is issued.
- The grant register is only sampled in IDLE; changes in CMD or RESP are ignored.

Optional Feature:
- Macro YCR1_ARB_MUX_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to RESP and increments each RESP cycle without mem_resp_valid.
  - When it reaches TMO_CYCLES, the block returns resp = 10 and rdata = 0 to channel sel, pulses arb_ack and goes to IDLE.
  - mem_resp_valid in the same cycle as the timeout wins (normal response).
  - A late memory response arriving after a timeout is ignored.
- Without the macro: no counter; RESP waits indefinitely.

Test Plan:
- Single read ch0:
  - Stimulus: core0_req = 1, cmd = 0, addr = 0x1000; arb_gnt = 00; mem_req_ack 2 cycles later; mem_resp_valid with rdata = 0xDEADBEEF 3 cycles after that.
  - Response: mem_addr = 0x1000; core0_req_ack pulses once; core0_resp = 01, core0_rdata = 0xDEADBEEF for 1 cycle; arb_ack pulses in the same cycle.
- Write ch1 with error:
  - Stimulus: core1 cmd = 1, wdata = 0x55AA, width = 01; arb_gnt = 01; mem_resp_err = 1.
  - Response: mem_cmd = 1, mem_wdata = 0x55AA, mem_width = 01; core1_resp = 10; core0_resp stays 00.
- Both channels requesting continuously, arbiter model alternating grants:
  - Response: mem_addr alternates ch0/ch1 addresses.
  - No CMD entry while arb_gnt = 11; exactly one arb_ack per transaction; no overlapping mem_req.
- Reset mid-transaction:
  - Stimulus: rstn low during RESP.
  - Response: all outputs return to reset values immediately; the subsequent mem_resp_valid produces no core resp and no arb_ack.
- Grant 10 or 11 in IDLE for 20 cycles:
  - Response: mem_req stays 0, arb_ack stays 0.
- With YCR1_ARB_MUX_TIMEOUT_EN and TMO_CYCLES = 8, no memory response:
  - Response: 8 cycles after entering RESP, core0_resp = 10 and arb_ack = 1.
  - A late mem_resp_valid is ignored.
